cdc_handshake_sync: RTL and testbench

//  Parametrised multi-bit clock-domain-crossing synchroniser using a req/ack handshake.

---
 rtl/cdc_handshake_sync_if.sv | 47 ++++
 rtl/cdc_handshake_sync.sv | 188 ++++++++++++++++++
 tb/tb_cdc_handshake_sync.sv | 307 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cdc_handshake_sync_if.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_handshake_sync_if
//  Purpose  : Bundles the source-side offer/status signals and the
//             destination-side word output of cdc_handshake_sync.
//  Signals  : ena, src_valid, src_data   - source controls (clk domain)
//             src_ready, src_drop, busy  - source status (clk domain)
//             dst_valid, dst_data        - delivered word (clk_dst domain)
//  Modports : master - the user of the synchroniser
//             slave  - the synchroniser itself
//  Revision : 1.0 - initial release
// ============================================================================
interface cdc_handshake_sync_if #(
    parameter int WIDTH = 8
);
    logic             ena;
    logic             src_valid;
    logic [WIDTH-1:0] src_data;
    logic             src_ready;
    logic             src_drop;
    logic             busy;
    logic             dst_valid;
    logic [WIDTH-1:0] dst_data;

    modport master (
        output ena,
        output src_valid,
        output src_data,
        input  src_ready,
        input  src_drop,
        input  busy,
        input  dst_valid,
        input  dst_data
    );

    modport slave (
        input  ena,
        input  src_valid,
        input  src_data,
        output src_ready,
        output src_drop,
        output busy,
        output dst_valid,
        output dst_data
    );
endinterface
`default_nettype wire

// File: rtl/cdc_handshake_sync.sv
`default_nettype none
// ============================================================================
//  Module   : cdc_handshake_sync
//  Purpose  : Multi-bit clock-domain crossing using a req/ack handshake.
//             A word accepted in the clk domain is parked in a hold register;
//             only the single-bit req/ack pair is synchronised, and the
//             destination copies the (by then stable) hold register when it
//             sees the req event. 2-phase (toggle) or 4-phase (level).
//  Ports    : clk     - source-domain clock
//             rst_n   - asynchronous active-low reset, both domains
//             clk_dst - destination-domain clock, asynchronous to clk
//             bus     - slave modport: ena/src_valid/src_data in,
//                       src_ready/src_drop/busy/dst_valid/dst_data out
//  Params   : WIDTH (>=1), SYNC_STAGES (2..4), PHASES (2 or 4)
//  Revision : 1.0 - initial release
// ============================================================================
module cdc_handshake_sync #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2,
    parameter int PHASES      = 4
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              clk_dst,
    cdc_handshake_sync_if.slave    bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2,
        ST_WAIT = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Reset synchronisers: assert asynchronously, release on the local clock
    // ------------------------------------------------------------------------
    logic [1:0] r_rst_src_sync;
    logic [1:0] r_rst_dst_sync;
    logic       w_rst_src_n;
    logic       w_rst_dst_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_src_sync <= 2'b00;
        end else begin
            r_rst_src_sync <= {r_rst_src_sync[0], 1'b1};
        end
    end

    always_ff @(posedge clk_dst or negedge rst_n) begin
        if (!rst_n) begin
            r_rst_dst_sync <= 2'b00;
        end else begin
            r_rst_dst_sync <= {r_rst_dst_sync[0], 1'b1};
        end
    end

    assign w_rst_src_n = r_rst_src_sync[1];
    assign w_rst_dst_n = r_rst_dst_sync[1];

    // ------------------------------------------------------------------------
    // Source domain
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic                   r_req;
    logic [WIDTH-1:0]       r_hold;
    logic                   r_busy;
    logic                   r_src_ready;
    logic                   r_src_drop;
    logic [SYNC_STAGES-1:0] r_ack_sync;
    logic                   w_ack_s;
    logic                   w_accept;
    logic                   w_ack;      // destination-domain flop output

    assign w_ack_s  = r_ack_sync[SYNC_STAGES-1];
    assign w_accept = bus.src_valid & r_src_ready;

    always_ff @(posedge clk or negedge w_rst_src_n) begin
        if (!w_rst_src_n) begin
            r_state     <= ST_IDLE;
            r_req       <= 1'b0;
            r_hold      <= '0;
            r_busy      <= 1'b0;
            r_src_ready <= 1'b0;
            r_src_drop  <= 1'b0;
            r_ack_sync  <= '0;
        end else begin
            r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], w_ack};

            // Sticky: any offer that is not taken is recorded, ena or not.
            if (bus.src_valid && !r_src_ready) begin
                r_src_drop <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_hold      <= bus.src_data;
                        r_busy      <= 1'b1;
                        r_src_ready <= 1'b0;
                        if (PHASES == 4) begin
                            r_req   <= 1'b1;
                            r_state <= ST_REQ;
                        end else begin
                            r_req   <= ~r_req;
                            r_state <= ST_WAIT;
                        end
                    end else begin
                        r_src_ready <= bus.ena;
                    end
                end
                ST_REQ: begin
                    if (w_ack_s) begin
                        r_req   <= 1'b0;
                        r_state <= ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (!w_ack_s) begin
                        r_busy      <= 1'b0;
                        r_src_ready <= bus.ena;
                        r_state     <= ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    // Toggle protocol: done once the echoed level matches req.
                    if (w_ack_s == r_req) begin
                        r_busy      <= 1'b0;
                        r_src_ready <= bus.ena;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.src_ready = r_src_ready;
    assign bus.src_drop  = r_src_drop;
    assign bus.busy      = r_busy;

    // ------------------------------------------------------------------------
    // Destination domain
    // ------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] r_req_sync;
    logic                   r_req_d;
    logic                   r_dst_valid;
    logic [WIDTH-1:0]       r_dst_data;
    logic                   w_req_s;
    logic                   w_event;

    assign w_req_s = r_req_sync[SYNC_STAGES-1];
    // The ack returned to the source is the synchronised req itself, so it
    // leaves this domain straight from a flop.
    assign w_ack   = w_req_s;

    if (PHASES == 4) begin : g_four_phase
        assign w_event = w_req_s & ~r_req_d;
    end else begin : g_two_phase
        assign w_event = w_req_s ^ r_req_d;
    end

    always_ff @(posedge clk_dst or negedge w_rst_dst_n) begin
        if (!w_rst_dst_n) begin
            r_req_sync  <= '0;
            r_req_d     <= 1'b0;
            r_dst_valid <= 1'b0;
            r_dst_data  <= '0;
        end else begin
            r_req_sync  <= {r_req_sync[SYNC_STAGES-2:0], r_req};
            r_req_d     <= w_req_s;
            r_dst_valid <= w_event;
            // hold has been stable since before req changed, so it is safe
            // to sample it here without its own synchroniser.
            if (w_event) begin
                r_dst_data <= r_hold;
            end
        end
    end

    assign bus.dst_valid = r_dst_valid;
    assign bus.dst_data  = r_dst_data;

endmodule
`default_nettype wire

// File: tb/tb_cdc_handshake_sync.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cdc_handshake_sync
//  Purpose  : Self-checking bench for cdc_handshake_sync. Four instances:
//             0: S=2 P=4, 1: S=2 P=2, 2: S=3 P=2, 3: S=3 P=4.
//             Expected words are queued per instance at accept time and
//             popped in order on every dst_valid pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cdc_handshake_sync;

    localparam int N_DUT   = 4;
    localparam int TIMEOUT = 4000;

    logic clk;
    logic clk_dst;
    logic rst_n;
    int   clk_per;
    int   dst_per;

    logic       ena  [N_DUT];
    logic       sv   [N_DUT];
    logic [7:0] sd   [N_DUT];
    logic       rdy  [N_DUT];
    logic       drop [N_DUT];
    logic       bsy  [N_DUT];
    logic       dv   [N_DUT];
    logic [7:0] dd   [N_DUT];

    logic [7:0] exp_q [N_DUT][$];
    int         n_recv [N_DUT];
    logic       pv [N_DUT];
    logic [7:0] pd [N_DUT];

    int n_checks = 0;
    int n_fail   = 0;

    cdc_handshake_sync_if #(.WIDTH(8)) bus0 ();
    cdc_handshake_sync_if #(.WIDTH(8)) bus1 ();
    cdc_handshake_sync_if #(.WIDTH(8)) bus2 ();
    cdc_handshake_sync_if #(.WIDTH(8)) bus3 ();

`define TB_BIND(K, B) \
    assign B.ena = ena[K]; assign B.src_valid = sv[K]; assign B.src_data = sd[K]; \
    assign rdy[K] = B.src_ready; assign drop[K] = B.src_drop; assign bsy[K] = B.busy; \
    assign dv[K] = B.dst_valid; assign dd[K] = B.dst_data;

    `TB_BIND(0, bus0)
    `TB_BIND(1, bus1)
    `TB_BIND(2, bus2)
    `TB_BIND(3, bus3)
`undef TB_BIND

    cdc_handshake_sync #(.WIDTH(8), .SYNC_STAGES(2), .PHASES(4)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .clk_dst(clk_dst), .bus(bus0));
    cdc_handshake_sync #(.WIDTH(8), .SYNC_STAGES(2), .PHASES(2)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .clk_dst(clk_dst), .bus(bus1));
    cdc_handshake_sync #(.WIDTH(8), .SYNC_STAGES(3), .PHASES(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .clk_dst(clk_dst), .bus(bus2));
    cdc_handshake_sync #(.WIDTH(8), .SYNC_STAGES(3), .PHASES(4)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .clk_dst(clk_dst), .bus(bus3));

    // Clocks with run-time adjustable periods.
    initial begin
        clk = 1'b0;
        forever begin
            #(clk_per / 2) clk = 1'b1;
            #(clk_per - clk_per / 2) clk = 1'b0;
        end
    end

    initial begin
        clk_dst = 1'b0;
        forever begin
            #(dst_per / 2) clk_dst = 1'b1;
            #(dst_per - dst_per / 2) clk_dst = 1'b0;
        end
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, observed=running expected=finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    // Destination-side scoreboard: every pulse must be a single cycle, carry
    // the oldest outstanding word, and data must not move between pulses.
    always @(negedge clk_dst) begin
        for (int k = 0; k < N_DUT; k++) begin
            if (!rst_n) begin
                pv[k] = 1'b0;
                pd[k] = 8'h00;
            end else begin
                if (dv[k]) begin
                    check($sformatf("dst_valid_width[%0d]", k), {31'd0, pv[k]}, 32'd0);
                    check($sformatf("dst_valid_expected[%0d]", k),
                          {31'd0, exp_q[k].size() != 0}, 32'd1);
                    if (exp_q[k].size() != 0) begin
                        check($sformatf("dst_data_order[%0d]", k), {24'd0, dd[k]},
                              {24'd0, exp_q[k].pop_front()});
                    end
                    n_recv[k]++;
                end else begin
                    check($sformatf("dst_data_hold[%0d]", k), {24'd0, dd[k]}, {24'd0, pd[k]});
                end
                pv[k] = dv[k];
                pd[k] = dd[k];
            end
        end
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_dst(input int n);
        repeat (n) @(negedge clk_dst);
    endtask

    // Offer one word honouring src_ready; the word is queued as expected at
    // the edge where it is taken.
    task automatic send(input int k, input logic [7:0] d);
        int t = 0;
        @(negedge clk);
        while (rdy[k] !== 1'b1 && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        if (t >= TIMEOUT) check($sformatf("send_ready_timeout[%0d]", k), {31'd0, rdy[k]}, 32'd1);
        sv[k] = 1'b1;
        sd[k] = d;
        @(posedge clk);
        exp_q[k].push_back(d);
        @(negedge clk);
        sv[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int t = 0;
        @(negedge clk);
        while (bsy[k] !== 1'b0 && t < TIMEOUT) begin
            @(negedge clk);
            t++;
        end
        if (t >= TIMEOUT) check($sformatf("busy_timeout[%0d]", k), {31'd0, bsy[k]}, 32'd0);
    endtask

    task automatic wait_recv(input int k, input int n);
        int t = 0;
        while (n_recv[k] < n && t < TIMEOUT) begin
            @(negedge clk_dst);
            t++;
        end
        check($sformatf("recv_count[%0d]", k), n_recv[k], n);
    endtask

    initial begin
        int base;
        clk_per = 10;
        dst_per = 37;
        for (int k = 0; k < N_DUT; k++) begin
            ena[k]    = 1'b1;
            sv[k]     = 1'b0;
            sd[k]     = 8'h00;
            n_recv[k] = 0;
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;

        // ---- Reset values ----------------------------------------------
        #50;
        for (int k = 0; k < N_DUT; k++) begin
            check($sformatf("reset_src_ready[%0d]", k), {31'd0, rdy[k]}, 32'd0);
            check($sformatf("reset_dst_data[%0d]", k), {24'd0, dd[k]}, 32'd0);
        end
        check("reset_src_drop", {31'd0, drop[0]}, 32'd0);
        check("reset_busy", {31'd0, bsy[0]}, 32'd0);
        check("reset_dst_valid", {31'd0, dv[0]}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_clk(5);
        wait_dst(4);

        // ---- 1: single 4-phase word, clk 10 / clk_dst 37 ----------------
        send(0, 8'hA5);
        check("t1_busy_after_accept", {31'd0, bsy[0]}, 32'd1);
        wait_recv(0, 1);
        wait_idle(0);
        wait_clk(2);
        check("t1_src_ready", {31'd0, rdy[0]}, 32'd1);
        check("t1_busy", {31'd0, bsy[0]}, 32'd0);
        check("t1_dst_data", {24'd0, dd[0]}, 32'h0000_00A5);

        // ---- 2: 2-phase back-to-back, clk 37 / clk_dst 10 ---------------
        clk_per = 37;
        dst_per = 10;
        wait_clk(2);
        send(1, 8'h01);
        send(1, 8'h02);
        send(1, 8'h03);
        wait_recv(1, 3);
        wait_idle(1);
        check("t2_src_drop", {31'd0, drop[1]}, 32'd0);
        check("t2_dst_data", {24'd0, dd[1]}, 32'h0000_0003);

        // ---- 3: offer while busy is dropped -----------------------------
        send(1, 8'h77);
        check("t3_busy", {31'd0, bsy[1]}, 32'd1);
        check("t3_src_ready", {31'd0, rdy[1]}, 32'd0);
        sv[1] = 1'b1;
        sd[1] = 8'h55;
        @(negedge clk);
        sv[1] = 1'b0;
        check("t3_src_drop_set", {31'd0, drop[1]}, 32'd1);
        wait_idle(1);
        wait_recv(1, 4);
        wait_dst(20);
        check("t3_only_first_word", n_recv[1], 4);
        check("t3_src_drop_sticky", {31'd0, drop[1]}, 32'd1);

        // ---- 4: reset after accept, before delivery ---------------------
        clk_per = 10;
        dst_per = 37;
        wait_clk(3);
        send(0, 8'h3C);
        rst_n = 1'b0;
        #1;
        check("t4_src_ready_in_reset", {31'd0, rdy[0]}, 32'd0);
        check("t4_busy_in_reset", {31'd0, bsy[0]}, 32'd0);
        check("t4_dst_valid_in_reset", {31'd0, dv[0]}, 32'd0);
        check("t4_dst_data_in_reset", {24'd0, dd[0]}, 32'd0);
        check("t4_src_drop_in_reset", {31'd0, drop[1]}, 32'd0);
        for (int k = 0; k < N_DUT; k++) exp_q[k].delete();
        base = n_recv[0];
        wait_clk(3);
        rst_n = 1'b1;
        @(negedge clk);
        check("t4_src_ready_held_after_release", {31'd0, rdy[0]}, 32'd0);
        wait_clk(2);
        check("t4_src_ready_after_release", {31'd0, rdy[0]}, 32'd1);
        wait_dst(30);
        check("t4_no_dst_valid", n_recv[0], base);
        check("t4_dst_data_zero", {24'd0, dd[0]}, 32'd0);

        // ---- 5: ena gating ----------------------------------------------
        ena[0] = 1'b0;
        wait_clk(2);
        check("t5_src_ready_ena0", {31'd0, rdy[0]}, 32'd0);
        sv[0] = 1'b1;
        sd[0] = 8'h99;
        wait_clk(3);
        sv[0] = 1'b0;
        check("t5_src_drop", {31'd0, drop[0]}, 32'd1);
        check("t5_no_busy", {31'd0, bsy[0]}, 32'd0);
        wait_dst(10);
        check("t5_no_transfer", n_recv[0], base);
        ena[0] = 1'b1;
        wait_clk(2);
        send(0, 8'h5A);
        ena[0] = 1'b0;
        wait_idle(0);
        wait_recv(0, base + 1);
        wait_dst(20);
        check("t5_delivered_once", n_recv[0], base + 1);
        check("t5_dst_data", {24'd0, dd[0]}, 32'h0000_005A);
        check("t5_src_ready_stays0", {31'd0, rdy[0]}, 32'd0);
        ena[0] = 1'b1;

        // ---- 6: random words, random clock ratio, S=3 both protocols -----
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    if (i % 100 == 0) dst_per = int'($urandom_range(3, 33));
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(2, 8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 1000; i++) begin
                    repeat ($urandom_range(0, 2)) @(negedge clk);
                    send(3, 8'($urandom));
                end
            end
        join
        wait_idle(2);
        wait_idle(3);
        wait_recv(2, 1000);
        wait_recv(3, 1000);
        check("t6_scoreboard_empty2", exp_q[2].size(), 0);
        check("t6_scoreboard_empty3", exp_q[3].size(), 0);
        check("t6_no_drop2", {31'd0, drop[2]}, 32'd0);
        check("t6_no_drop3", {31'd0, drop[3]}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
